// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for a 16-entry memory_unit FIFO
module fifo_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    output logic              wen,
    output logic              ren,
    output logic [ADDR_W-1:0] wrAddress,
    output logic [ADDR_W-1:0] rdAddress,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, overflow_q, underflow_q;
    logic              push_ok, pop_ok;

    assign full      = count_q == DEPTH;
    assign empty     = count_q == '0;
    assign wen       = push_ok;
    assign ren       = pop_ok;
    assign wrAddress = wr_ptr_q;
    assign rdAddress = rd_ptr_q;
    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Accept requests; pushes are refused while full even with a pop so the same address is never read and written together
    always_comb begin
        push_ok  = push & ~full & ~flush;
        pop_ok   = pop & ~empty & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(push_ok);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(pop_ok);
        count_d  = flush ? '0 :
                   (push_ok && !pop_ok) ? count_q + 1'b1 :
                   (pop_ok && !push_ok) ? count_q - 1'b1 : count_q;
    end

    // State registers plus one-cycle read-valid and error pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= pop_ok;
            overflow_q  <= push & full & ~flush;
            underflow_q <= pop & empty & ~flush;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized check of fifo_ctrl against a queue-based FIFO model
module tb_fifo_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic        wen, ren, rd_valid, full, empty, overflow, underflow;
    logic [3:0]  wrAddress, rdAddress;
    logic [4:0]  count;
    logic [14:0] din = '0, dout = '0;
    logic [14:0] mem [16];

    int n_chk = 0, n_pass = 0;
    logic [14:0] fq [$];
    int          wcnt = 0, rcnt = 0;
    bit          m_rv = 0, m_ov = 0, m_uf = 0;
    logic [14:0] m_data = '0;

    fifo_ctrl #(.ADDR_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .push(push), .pop(pop), .flush(flush),
        .wen(wen), .ren(ren), .wrAddress(wrAddress), .rdAddress(rdAddress),
        .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Stand-in for memory_unit: write on wen, registered read on ren
    always @(posedge clock) begin
        if (wen) mem[wrAddress] <= din;
        if (ren) dout <= mem[rdAddress];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic check_regs();
        chk("count", 32'(count), 32'(fq.size()));
        chk("full", 32'(full), 32'(fq.size() == 16));
        chk("empty", 32'(empty), 32'(fq.size() == 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_uf));
        if (m_rv) chk("dataOut", 32'(dout), 32'(m_data));
    endtask

    task automatic step(input logic p, input logic pp, input logic f, input logic [14:0] d);
        bit fm, em, ew, er;
        check_regs();
        push = p; pop = pp; flush = f; din = d;
        #1;
        fm = fq.size() == 16;
        em = fq.size() == 0;
        ew = p && !fm && !f;
        er = pp && !em && !f;
        chk("wen", 32'(wen), 32'(ew));
        chk("ren", 32'(ren), 32'(er));
        chk("wrAddress", 32'(wrAddress), 32'(wcnt % 16));
        chk("rdAddress", 32'(rdAddress), 32'(rcnt % 16));
        @(posedge clock);
        m_ov = p && fm && !f;
        m_uf = pp && em && !f;
        m_rv = er;
        if (f) begin
            fq.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (er) begin m_data = fq.pop_front(); rcnt++; end
            if (ew) begin fq.push_back(d); wcnt++; end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        push = 0; pop = 0; flush = 0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wen_ren", {30'b0, wen, ren}, 0);
        chk("rst_addr", {24'b0, wrAddress, rdAddress}, 0);
        chk("rst_flags", {29'b0, rd_valid, overflow, underflow}, 0);
        fq.delete();
        wcnt = 0; rcnt = 0;
        m_rv = 0; m_ov = 0; m_uf = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 15'(10 + i));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 0, 15'(i));
        step(1, 1, 0, 15'h7ff);
        step(1, 0, 0, 15'h123);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 15'h55);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 15'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 0, 15'($urandom));
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 15'($urandom));
        step(1, 1, 1, 15'h3);
        step(1, 0, 0, 15'h44);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 15'($urandom));
        do_reset();
        step(1, 0, 0, 15'h66);
        for (int b = 0; b < 8; b++) begin
            int pp = (b % 2) ? 30 : 75;
            for (int i = 0; i < 40; i++)
                step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
                     $urandom_range(0, 49) == 0, 15'($urandom));
        end
        step(0, 0, 0, 0);
        check_regs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
